// File: rtl/mpshare_arbiter.sv
// rtl/mpshare_arbiter.sv - round-robin share of one fixed-latency multiplier among NREQ requesters
// Products are tagged on issue and returned to the issuing requester MPLAT+2 cycles after grant.
module mpshare_arbiter #(
  parameter int NREQ  = 2,
  parameter int MPLAT = 1,
  parameter int CANDW = 24,
  parameter int LIERW = 16,
  parameter int PRODW = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*CANDW-1:0] mpcand_i,
  input  logic [NREQ*LIERW-1:0] mplier_i,
  output logic [NREQ-1:0]       gnt_o,
  input  logic                  mpready_i,
  output logic [CANDW-1:0]      mpcand_o,
  output logic [LIERW-1:0]      mplier_o,
  input  logic [PRODW-1:0]      mprod_i,
  output logic [PRODW-1:0]      mprod_o,
  output logic [NREQ-1:0]       prod_vld_o,
  output logic                  busy_o
);

  localparam int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [TAGW-1:0]  ptr_q, ptr_d;
  logic [TAGW-1:0]  win;
  logic [TAGW:0]    idx;
  logic [NREQ-1:0]  cand, gnt;
  logic [CANDW-1:0] mpcand_q, mpcand_d;
  logic [LIERW-1:0] mplier_q, mplier_d;
  logic [PRODW-1:0] mprod_q, mprod_d;
  logic [NREQ-1:0]  prod_vld_q, prod_vld_d;
  logic [MPLAT:0]   trk_vld_q;
  logic [TAGW-1:0]  trk_tag_q [MPLAT+1];

  // Scan from the highest offset down so the candidate closest to the pointer is written last and wins.
  always_comb begin
    cand = req_i & {NREQ{mpready_i}};
    gnt  = '0;
    win  = '0;
    idx  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_q} + (TAGW+1)'(i);
      if (idx >= (TAGW+1)'(NREQ)) idx = idx - (TAGW+1)'(NREQ);
      if (cand[idx[TAGW-1:0]]) begin
        win = idx[TAGW-1:0];
        gnt = NREQ'(1) << idx[TAGW-1:0];
      end
    end
    if (!rst) gnt = '0;
  end

  always_comb begin
    ptr_d    = ptr_q;
    mpcand_d = mpcand_q;
    mplier_d = mplier_q;
    if (|gnt) begin
      ptr_d    = (win == TAGW'(NREQ - 1)) ? '0 : win + TAGW'(1);
      mpcand_d = mpcand_i[win*CANDW +: CANDW];
      mplier_d = mplier_i[win*LIERW +: LIERW];
    end
    mprod_d    = mprod_q;
    prod_vld_d = '0;
    if (trk_vld_q[MPLAT]) begin
      mprod_d    = mprod_i;
      prod_vld_d = NREQ'(1) << trk_tag_q[MPLAT];
    end
  end

  // The tracker never stalls: mpready_i only gates new issues, in-flight slots keep moving.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q      <= '0;
      mpcand_q   <= '0;
      mplier_q   <= '0;
      mprod_q    <= '0;
      prod_vld_q <= '0;
      trk_vld_q  <= '0;
      for (int s = 0; s <= MPLAT; s++) trk_tag_q[s] <= '0;
    end else begin
      ptr_q        <= ptr_d;
      mpcand_q     <= mpcand_d;
      mplier_q     <= mplier_d;
      mprod_q      <= mprod_d;
      prod_vld_q   <= prod_vld_d;
      trk_vld_q[0] <= |gnt;
      trk_tag_q[0] <= win;
      for (int s = 1; s <= MPLAT; s++) begin
        trk_vld_q[s] <= trk_vld_q[s-1];
        trk_tag_q[s] <= trk_tag_q[s-1];
      end
    end
  end

  assign gnt_o      = gnt;
  assign mpcand_o   = mpcand_q;
  assign mplier_o   = mplier_q;
  assign mprod_o    = mprod_q;
  assign prod_vld_o = prod_vld_q;
  assign busy_o     = |trk_vld_q;

endmodule
